// File: rtl/router_pkt_tx.sv
`default_nettype none
// ============================================================================
// Module      : router_pkt_tx
// Description : Packet transmitter feeding the source side of a 1x3 router.
//               Takes a command (destination, length, parity-corruption flag),
//               buffers the full payload from an upstream byte stream, then
//               sends header, payload and parity bytes back-to-back, framed by
//               pkt_valid and stalled by router busy.
// Ports       : clock        rising-edge clock
//               resetn       synchronous active-low reset
//               cmd_valid    command request        (cmd_ready: high in IDLE)
//               cmd_addr     destination port       cmd_len: payload length
//               cmd_bad_par  invert transmitted parity byte
//               pay_valid    payload byte valid     (pay_ready: high in LOAD)
//               pay_data     payload byte
//               busy         router busy, current byte is not consumed
//               data_in      byte to router         pkt_valid: header/payload
//               pkt_done     one-cycle pulse after parity byte consumed
// Revision    : 1.0 - initial release
// ============================================================================
module router_pkt_tx #(
    parameter int MAX_LEN = 63
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_addr,
    input  logic [5:0] cmd_len,
    input  logic       cmd_bad_par,
    input  logic       pay_valid,
    output logic       pay_ready,
    input  logic [7:0] pay_data,
    input  logic       busy,
    output logic [7:0] data_in,
    output logic       pkt_valid,
    output logic       pkt_done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_HDR  = 3'd2,
        S_PAY  = 3'd3,
        S_PAR  = 3'd4,
        S_GAP  = 3'd5
    } state_t;

    state_t     r_state,   w_state_nxt;
    logic [5:0] r_len,     w_len_nxt;
    logic [5:0] r_wptr,    w_wptr_nxt;
    logic [5:0] r_rptr,    w_rptr_nxt;
    logic [7:0] r_hdr,     w_hdr_nxt;
    logic [7:0] r_par,     w_par_nxt;
    logic       r_bad_par, w_bad_nxt;
    logic       w_wr_en;
    logic       w_take;
    logic [7:0] w_rd_byte;

    logic [7:0] r_buf [0:MAX_LEN-1];

    // Registered output images, computed from the next state so every output
    // is a flop and the next byte is present the cycle after a consume.
    logic [7:0] r_data,      w_data_nxt;
    logic       r_pkt_valid, w_pv_nxt;
    logic       r_pkt_done,  w_done_nxt;
    logic       r_cmd_ready, w_cmd_rdy_nxt;
    logic       r_pay_ready, w_pay_rdy_nxt;

    assign data_in   = r_data;
    assign pkt_valid = r_pkt_valid;
    assign pkt_done  = r_pkt_done;
    assign cmd_ready = r_cmd_ready;
    assign pay_ready = r_pay_ready;

    assign w_take    = ((r_state == S_HDR) || (r_state == S_PAY) || (r_state == S_PAR)) && !busy;
    assign w_rd_byte = r_buf[r_rptr];

    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_wptr_nxt  = r_wptr;
        w_rptr_nxt  = r_rptr;
        w_hdr_nxt   = r_hdr;
        w_par_nxt   = r_par;
        w_bad_nxt   = r_bad_par;
        w_wr_en     = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_hdr_nxt   = {cmd_len, cmd_addr};
                    w_par_nxt   = {cmd_len, cmd_addr};
                    w_len_nxt   = cmd_len;
                    w_bad_nxt   = cmd_bad_par;
                    w_wptr_nxt  = 6'd0;
                    w_rptr_nxt  = 6'd0;
                    w_state_nxt = (cmd_len == 6'd0) ? S_HDR : S_LOAD;
                end
            end
            S_LOAD: begin
                if (pay_valid) begin
                    w_wr_en    = 1'b1;
                    w_wptr_nxt = r_wptr + 6'd1;
                    if ((r_wptr + 6'd1) == r_len) begin
                        w_state_nxt = S_HDR;
                    end
                end
            end
            S_HDR: begin
                if (w_take) begin
                    w_state_nxt = (r_len != 6'd0) ? S_PAY : S_PAR;
                end
            end
            S_PAY: begin
                if (w_take) begin
                    w_par_nxt  = r_par ^ w_rd_byte;
                    w_rptr_nxt = r_rptr + 6'd1;
                    if ((r_rptr + 6'd1) == r_len) begin
                        w_state_nxt = S_PAR;
                    end
                end
            end
            S_PAR: begin
                if (w_take) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output images follow the state being entered (or held), so a stalled
    // byte is regenerated from unchanged state and therefore holds exactly.
    always_comb begin
        w_data_nxt    = 8'h00;
        w_pv_nxt      = 1'b0;
        w_cmd_rdy_nxt = 1'b0;
        w_pay_rdy_nxt = 1'b0;
        case (w_state_nxt)
            S_IDLE: w_cmd_rdy_nxt = 1'b1;
            S_LOAD: w_pay_rdy_nxt = 1'b1;
            S_HDR: begin
                w_data_nxt = w_hdr_nxt;
                w_pv_nxt   = 1'b1;
            end
            S_PAY: begin
                w_data_nxt = r_buf[w_rptr_nxt];
                w_pv_nxt   = 1'b1;
            end
            S_PAR:   w_data_nxt = w_par_nxt ^ {8{w_bad_nxt}};
            default: w_data_nxt = 8'h00;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_len       <= 6'd0;
            r_wptr      <= 6'd0;
            r_rptr      <= 6'd0;
            r_hdr       <= 8'h00;
            r_par       <= 8'h00;
            r_bad_par   <= 1'b0;
            r_data      <= 8'h00;
            r_pkt_valid <= 1'b0;
            r_pkt_done  <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_pay_ready <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_len       <= w_len_nxt;
            r_wptr      <= w_wptr_nxt;
            r_rptr      <= w_rptr_nxt;
            r_hdr       <= w_hdr_nxt;
            r_par       <= w_par_nxt;
            r_bad_par   <= w_bad_nxt;
            r_data      <= w_data_nxt;
            r_pkt_valid <= w_pv_nxt;
            r_pkt_done  <= w_done_nxt;
            r_cmd_ready <= w_cmd_rdy_nxt;
            r_pay_ready <= w_pay_rdy_nxt;
        end
    end

    // Payload storage carries no reset; contents are only read after being
    // written for the current packet.
    always_ff @(posedge clock) begin
        if (resetn && w_wr_en) begin
            r_buf[r_wptr] <= pay_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_router_pkt_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_pkt_tx
// Description : Directed self-checking bench for router_pkt_tx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_pkt_tx;

    logic       clock = 1'b0;
    logic       resetn;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_addr;
    logic [5:0] cmd_len;
    logic       cmd_bad_par;
    logic       pay_valid;
    logic       pay_ready;
    logic [7:0] pay_data;
    logic       busy;
    logic [7:0] data_in;
    logic       pkt_valid;
    logic       pkt_done;

    int n_checks = 0;
    int n_err    = 0;

    // Expected byte stream: [0] header, [1..len] payload, [len+1] parity.
    logic [7:0] exp_b [0:65];
    int         stall [0:65];

    router_pkt_tx #(.MAX_LEN(63)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .cmd_bad_par (cmd_bad_par),
        .pay_valid   (pay_valid),
        .pay_ready   (pay_ready),
        .pay_data    (pay_data),
        .busy        (busy),
        .data_in     (data_in),
        .pkt_valid   (pkt_valid),
        .pkt_done    (pkt_done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stalls();
        for (int i = 0; i < 66; i++) stall[i] = 0;
    endtask

    task automatic send_cmd(input logic [1:0] addr, input logic [5:0] len, input logic bad);
        int t;
        t = 0;
        while (!cmd_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
        cmd_addr    = addr;
        cmd_len     = len;
        cmd_bad_par = bad;
        cmd_valid   = 1'b1;
        @(negedge clock);
        cmd_valid   = 1'b0;
    endtask

    // Streams exp_b[1..n]; optionally drops pay_valid for one cycle.
    task automatic load_pay(input int n, input bit with_gap);
        int i;
        int t;
        i = 0;
        t = 0;
        while (i < n && t < 500) begin
            pay_valid = !(with_gap && t == 1);
            pay_data  = exp_b[i+1];
            if (pay_valid && pay_ready) i++;
            @(negedge clock);
            t++;
        end
        pay_valid = 1'b0;
        check("load_count", i, n);
    endtask

    // Checks n bytes (header..parity) with per-byte busy stalls, then the
    // pkt_done pulse in the gap cycle.
    task automatic run_packet(input int n);
        int t;
        t = 0;
        while (!pkt_valid && t < 200) begin
            @(negedge clock);
            t++;
        end
        check("hdr_wait", {31'd0, pkt_valid}, 32'd1);
        for (int k = 0; k < n; k++) begin
            for (int s = 0; s < stall[k]; s++) begin
                busy = 1'b1;
                check($sformatf("hold%0d_data", k), {24'd0, data_in}, {24'd0, exp_b[k]});
                check($sformatf("hold%0d_pv", k), {31'd0, pkt_valid}, {31'd0, (k < n-1)});
                @(negedge clock);
            end
            busy = 1'b0;
            check($sformatf("byte%0d_data", k), {24'd0, data_in}, {24'd0, exp_b[k]});
            check($sformatf("byte%0d_pv", k), {31'd0, pkt_valid}, {31'd0, (k < n-1)});
            @(negedge clock);
        end
        check("done_pulse", {31'd0, pkt_done}, 32'd1);
        check("gap_pv", {31'd0, pkt_valid}, 32'd0);
        check("gap_data", {24'd0, data_in}, 32'd0);
        @(negedge clock);
        check("done_clear", {31'd0, pkt_done}, 32'd0);
    endtask

    initial begin
        resetn      = 1'b0;
        cmd_valid   = 1'b0;
        cmd_addr    = 2'd0;
        cmd_len     = 6'd0;
        cmd_bad_par = 1'b0;
        pay_valid   = 1'b0;
        pay_data    = 8'h00;
        busy        = 1'b0;
        clear_stalls();

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_pay_ready", {31'd0, pay_ready}, 32'd0);
        check("rst_pkt_valid", {31'd0, pkt_valid}, 32'd0);
        check("rst_pkt_done",  {31'd0, pkt_done},  32'd0);
        check("rst_data",      {24'd0, data_in},   32'd0);
        resetn = 1'b1;
        @(negedge clock);
        check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Basic: addr=1 len=3 -> 0D 01 02 04, parity 0A (one pay_valid gap)
        exp_b[0] = 8'h0D; exp_b[1] = 8'h01; exp_b[2] = 8'h02; exp_b[3] = 8'h04; exp_b[4] = 8'h0A;
        send_cmd(2'd1, 6'd3, 1'b0);
        check("load_pay_ready", {31'd0, pay_ready}, 32'd1);
        load_pay(3, 1'b1);
        run_packet(5);

        // Busy stall: 1 cycle on 0x01, 4 cycles on 0x02
        clear_stalls();
        stall[1] = 1;
        stall[2] = 4;
        send_cmd(2'd1, 6'd3, 1'b0);
        load_pay(3, 1'b0);
        run_packet(5);
        clear_stalls();

        // Zero length: header 02, parity 02, no LOAD phase
        exp_b[0] = 8'h02; exp_b[1] = 8'h02;
        send_cmd(2'd2, 6'd0, 1'b0);
        check("zl_no_load", {31'd0, pay_ready}, 32'd0);
        check("zl_hdr_now", {31'd0, pkt_valid}, 32'd1);
        run_packet(2);

        // Max length with bad parity: header FC, payload 00..3E.
        // XOR(00..3E) = 3F, FC^3F = C3, inverted = 3C.
        exp_b[0] = 8'hFC;
        for (int i = 0; i < 63; i++) exp_b[i+1] = 8'(i);
        exp_b[64] = 8'h3C;
        send_cmd(2'd0, 6'd63, 1'b1);
        load_pay(63, 1'b0);
        run_packet(65);

        // Back-to-back: cmd_valid held through packet A, must not queue
        cmd_addr    = 2'd1;
        cmd_len     = 6'd0;
        cmd_bad_par = 1'b0;
        cmd_valid   = 1'b1;
        @(negedge clock);
        cmd_addr  = 2'd2;
        exp_b[0] = 8'h01; exp_b[1] = 8'h01;
        run_packet(2);
        check("b2b_idle_ready", {31'd0, cmd_ready}, 32'd1);
        check("b2b_idle_pv",    {31'd0, pkt_valid}, 32'd0);
        @(negedge clock);
        check("b2b_hdr_pv",   {31'd0, pkt_valid}, 32'd1);
        check("b2b_hdr_data", {24'd0, data_in},   32'h02);
        cmd_valid = 1'b0;
        exp_b[0] = 8'h02; exp_b[1] = 8'h02;
        run_packet(2);
        @(negedge clock);
        check("b2b_no_third", {31'd0, pkt_valid}, 32'd0);

        // Reset in the middle of the payload
        exp_b[1] = 8'h11; exp_b[2] = 8'h22; exp_b[3] = 8'h33;
        send_cmd(2'd1, 6'd3, 1'b0);
        load_pay(3, 1'b0);
        @(negedge clock);
        @(negedge clock);
        check("mid_pay_pv", {31'd0, pkt_valid}, 32'd1);
        check("mid_pay_data", {24'd0, data_in}, 32'h22);
        resetn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("mrst_data", {24'd0, data_in},   32'd0);
            check("mrst_pv",   {31'd0, pkt_valid}, 32'd0);
            check("mrst_rdy",  {31'd0, cmd_ready}, 32'd0);
        end
        resetn = 1'b1;
        @(negedge clock);
        check("mrst_rel_rdy",  {31'd0, cmd_ready}, 32'd1);
        check("mrst_rel_pv",   {31'd0, pkt_valid}, 32'd0);
        check("mrst_rel_data", {24'd0, data_in},   32'd0);
        check("mrst_rel_done", {31'd0, pkt_done},  32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
